// File: rtl/multdiv_unit_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit and the ALU control decode.
package multdiv_unit_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [4:0] MULT_OP = 5'b00110;
  localparam logic [4:0] DIV_OP  = 5'b00111;
  localparam int ITER_BITS = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_iter.sv
// Unsigned one-bit-per-clock datapath: shift-add multiply or restoring divide on magnitudes.
module multdiv_iter
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             load_div,
  input  logic             step,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH-1:0] md_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             div_reg;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  // Multiply: {hi,lo} holds partial product with the multiplier draining out of lo.
  assign sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, md_reg} : '0);

  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  assign shifted = {hi_reg, lo_reg[WIDTH-1]};
  assign fits    = shifted >= {1'b0, md_reg};
  assign diff    = shifted[WIDTH-1:0] - md_reg;

  always_comb begin
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], lo_reg[WIDTH-1:1]};
    if (div_reg) begin
      hi_next = fits ? diff : shifted[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], fits};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_reg  <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
      div_reg <= 1'b0;
    end else if (load) begin
      md_reg  <= operand_b;
      lo_reg  <= operand_a;
      hi_reg  <= '0;
      div_reg <= load_div;
    end else if (step) begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide: FSM, sign handling, exception detection, output registers.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t                 state_reg, state_next;
  logic [ITER_BITS-1:0]   cnt_reg;
  logic                   sign_reg;
  logic [WIDTH-1:0]       result_reg;
  logic                   exc_reg;

  logic [WIDTH-1:0]       abs_a, abs_b;
  logic                   start, div_by_zero, load, step, last;
  logic [WIDTH-1:0]       hi_next, lo_next;
  logic [2*WIDTH-1:0]     prod_mag, prod_signed;
  logic [WIDTH-1:0]       quot_signed;
  logic                   mult_ovf, div_ovf;

  // Magnitude of the most negative value wraps to itself, which is correct read as unsigned.
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign start       = (state_reg == IDLE) && (ctrl_MULT || ctrl_DIV);
  assign div_by_zero = !ctrl_MULT && (data_operandB == '0);
  assign load        = start && !div_by_zero;
  assign step        = (state_reg == MULT_RUN) || (state_reg == DIV_RUN);
  assign last        = step && (cnt_reg == ITER_BITS'(WIDTH - 1));

  multdiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .load_div  (!ctrl_MULT),
    .step      (step),
    .operand_a (abs_a),
    .operand_b (abs_b),
    .hi_next   (hi_next),
    .lo_next   (lo_next)
  );

  // Final result is formed from the last iteration's combinational output so it lands with DONE.
  assign prod_mag    = {hi_next, lo_next};
  assign prod_signed = sign_reg ? -prod_mag : prod_mag;
  assign mult_ovf    = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
  assign quot_signed = sign_reg ? -lo_next : lo_next;
  assign div_ovf     = !sign_reg && lo_next[WIDTH-1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ctrl_MULT)        state_next = MULT_RUN;
        else if (ctrl_DIV)    state_next = div_by_zero ? DONE : DIV_RUN;
      end
      MULT_RUN, DIV_RUN: if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sign_reg   <= 1'b0;
      result_reg <= '0;
      exc_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        cnt_reg  <= '0;
        sign_reg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        if (div_by_zero) begin
          result_reg <= '0;
          exc_reg    <= 1'b1;
        end
      end else if (step) begin
        cnt_reg <= cnt_reg + ITER_BITS'(1);
        if (last) begin
          result_reg <= (state_reg == DIV_RUN) ? quot_signed : prod_signed[WIDTH-1:0];
          exc_reg    <= (state_reg == DIV_RUN) ? div_ovf : mult_ovf;
        end
      end
    end
  end

  assign data_result    = result_reg;
  assign data_exception = exc_reg;
  assign data_resultRDY = (state_reg == DONE);
  assign busy           = step;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed vectors, monitor checks result, flag, latency and busy time.
module tb_multdiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           issue;
    int           lat;
    int           busy_cycles;
    string        name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: counts busy cycles and checks every completion pulse against the queue head.
  always @(negedge clock) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (data_resultRDY) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rdy actual=1 required=0 at cycle %0d", cyc);
        end else begin
          mon_e = sbq.pop_front();
          check({mon_e.name, "_result"}, data_result, mon_e.res);
          check({mon_e.name, "_exception"}, 32'(data_exception), 32'(mon_e.exc));
          check({mon_e.name, "_latency"}, 32'(cyc - mon_e.issue), 32'(mon_e.lat));
          check({mon_e.name, "_busy"}, 32'(busy_cnt), 32'(mon_e.busy_cycles));
          $display("txn %s A=%0h B=%0h result=%0h exc=%0b latency=%0d", mon_e.name,
                   data_operandA, data_operandB, data_result, data_exception, cyc - mon_e.issue);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input string name, input logic m, input logic d,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic exc, input int lat, input int bz);
    exp_t e;
    @(negedge clock);
    e.res = res; e.exc = exc; e.issue = cyc; e.lat = lat; e.busy_cycles = bz; e.name = name;
    sbq.push_back(e);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV = d;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (sbq.size() == 0) break;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual=pending required=done", name);
      sbq.delete();
    end
    @(negedge clock);
  endtask

  task automatic run(input string name, input logic m, input logic d,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] res, input logic exc, input int lat, input int bz);
    issue(name, m, d, a, b, res, exc, lat, bz);
    wait_done(name);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset_result", data_result, 32'h0);
    check("reset_exception", 32'(data_exception), 32'h0);
    check("reset_rdy", 32'(data_resultRDY), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    run("mul_7_m3",      1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 33, 32);
    run("mul_ovf",       1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1, 33, 32);
    run("mul_min_1",     1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 0, 33, 32);
    run("mul_m5_m4",     1, 0, 32'hFFFF_FFFB,  32'hFFFF_FFFC, 32'd20,        0, 33, 32);
    run("div_m7_2",      0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0, 33, 32);
    run("div_min_m1",    0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 33, 32);
    run("div_by_zero",   0, 1, 32'd5,          32'd0,         32'h0,         1, 1,  0);
    run("div_zero_by_5", 0, 1, 32'd0,          32'd5,         32'h0,         0, 33, 32);
    run("div_100_m7",    0, 1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 33, 32);
    run("div_7_m8",      0, 1, 32'd7,          32'hFFFF_FFF8, 32'h0,         0, 33, 32);

    // Both strobes: multiply wins; a divide strobe mid-run must be ignored.
    issue("both_6_3", 1, 1, 32'd6, 32'd3, 32'd18, 0, 33, 32);
    repeat (5) @(negedge clock);
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_done("both_6_3");
    repeat (3) @(negedge clock);

    // Abort a multiply around iteration 10 with reset; no completion may follow.
    @(negedge clock);
    data_operandA = 32'h0000_1234;
    data_operandB = 32'h0000_5678;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_result", data_result, 32'h0);
    check("abort_exception", 32'(data_exception), 32'h0);
    check("abort_rdy", 32'(data_resultRDY), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    $display("txn abort_reset result=%0h busy=%0b", data_result, busy);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);

    run("div_9_3", 0, 1, 32'd9, 32'd3, 32'd3, 0, 33, 32);
    repeat (3) @(negedge clock);
    check("hold_result", data_result, 32'd3);
    check("hold_rdy", 32'(data_resultRDY), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multi-cycle signed multiply/divide unit for the pipeline.
- Executes the R-type ALU opcodes mult (00110) and div (00111), which the ALU control path does not send to the single-cycle ALU.
- Issue logic pulses a start strobe with both operands. The unit iterates one bit per clock and returns a one-cycle result-ready pulse with result and exception flag, used to write back $rd or $rstatus.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH
MULT_OP, 5'b00110, ALU opcode decoded upstream as multiply
DIV_OP, 5'b00111, ALU opcode decoded upstream as divide

Ports:
clock  input  1  single system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
data_operandA  input  WIDTH  multiplicand / dividend (two's complement)
data_operandB  input  WIDTH  multiplier / divisor (two's complement)
ctrl_MULT  input  1  start multiply; sampled only in IDLE
ctrl_DIV  input  1  start divide; sampled only in IDLE
data_result  output  WIDTH  low WIDTH bits of product, or quotient
data_exception  output  1  overflow or divide-by-zero; valid with data_resultRDY
data_resultRDY  output  1  one-cycle completion pulse
busy  output  1  high in MULT_RUN/DIV_RUN; issue logic stalls mult/div while high

Behaviour:
- Reset (async, reset_n low): state IDLE, counter 0. data_result=0, data_exception=0, data_resultRDY=0, busy=0. Reset mid-operation aborts with no RDY pulse.
- States: IDLE, MULT_RUN, DIV_RUN, DONE.
- IDLE: ctrl_MULT high at edge N:
  - latch |A|, |B|, result sign = A[31]^B[31], counter=0;
  - go to MULT_RUN.
- IDLE: ctrl_DIV high at edge N:
  - B==0: go straight to DONE with result 0, exception 1 (RDY visible in cycle after N);
  - else latch magnitudes and sign, go to DIV_RUN.
- Both strobes high in IDLE: multiply wins; div is dropped.
- Strobes in any state other than IDLE are ignored (no queueing).
- MULT_RUN: unsigned shift-add on magnitudes, one multiplier bit per edge, 2*WIDTH accumulator.
- DIV_RUN: unsigned restoring division, one quotient bit per edge.
- Counter increments each iteration. After WIDTH iterations (edge N+32), apply sign correction, register outputs, go to DONE.
- DONE: data_resultRDY=1 for exactly this cycle, then IDLE on next edge. A strobe present in DONE is ignored.
- Latency: RDY high in the cycle following edge N+32 (33rd cycle after the start cycle), fixed for all operands except divide-by-zero.
- Multiply result: low WIDTH bits of the signed 64-bit product.
  - exception=1 when product[63:31] is not all-equal (does not fit signed 32);
  - result still the truncated low word.
- Divide result: quotient truncated toward zero; remainder discarded.
  - 0x80000000 / -1 gives result 0x80000000, exception=1.
  - Dividend 0 gives result 0, exception 0.
- Sign correction: negate magnitude result when sign=1 and magnitude≠0. |0x80000000| is handled as unsigned 0x80000000, so it has no overflow in the magnitude path.
- data_result and data_exception hold their last values until the next completion; consumers qualify them only with data_resultRDY.

Decomposition:
- Shared package holds:
  - MULT_OP/DIV_OP opcode constants (shared with ALU control decode);
  - state encoding localparams (IDLE=2'd0, MULT_RUN=2'd1, DIV_RUN=2'd2, DONE=2'd3);
  - ITER_BITS=$clog2(WIDTH)+1.
- One sub-module, multdiv_iter: unsigned one-bit-per-cycle datapath (accumulator/remainder, shift register, add/subtract, mode select).
- Top level keeps the FSM, counter, sign/abs handling, exception logic and output registers.

Test Plan:
- ctrl_MULT, A=7, B=-3 -> RDY exactly 33 cycles after start; result 0xFFFFFFEB (-21), exception 0; busy high for cycles 1..32.
- ctrl_MULT, A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1; A=0x80000000, B=1 -> result 0x80000000, exception 0.
- ctrl_DIV, A=-7, B=2 -> result 0xFFFFFFFD (-3), exception 0; A=0x80000000, B=-1 -> result 0x80000000, exception 1.
- ctrl_DIV, A=5, B=0 -> RDY in cycle after start, result 0, exception 1, busy never high.
- ctrl_MULT and ctrl_DIV together with A=6, B=3 -> multiply executes, result 18; ctrl_DIV pulsed mid-run -> ignored, exactly one RDY pulse.
- reset_n low at iteration 10 of a multiply -> all outputs 0 immediately; no RDY pulse; next ctrl_DIV 9/3 -> result 3 after 33 cycles.
